// File: rtl/sam_sequencer.sv
// rtl/sam_sequencer.sv - SAM host-side sequencer: serial key load, then RLE-coded payload words
module sam_sequencer #(
   parameter int KEY_W  = 32,
   parameter int N_W    = 4,
   parameter int HI_LEN = 12,
   parameter int LO_LEN = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [N_W-1:0]   cfg_n,
   input  logic [KEY_W-1:0] cfg_d,
   input  logic [KEY_W-1:0] cfg_mod,
   input  logic             dat_valid,
   output logic             dat_ready,
   input  logic [KEY_W-1:0] dat_bits,
   output logic             str,
   output logic             mode,
   output logic             busy,
   output logic             done
);

   localparam int TOT   = N_W + 2 * KEY_W;
   localparam int CNT_W = $clog2(TOT);
   localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOT - 1);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(KEY_W - 1);
   localparam logic [4:0]       HI_M1    = 5'(HI_LEN - 1);
   localparam logic [4:0]       LO_M1    = 5'(LO_LEN - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DAT, SEND} state_t;

   state_t           state, next_state;
   logic [TOT-1:0]   cfg_sh;
   logic [CNT_W-1:0] cnt;
   logic [KEY_W-1:0] dat_sh;
   logic [KEY_W-1:0] dat_nxt;
   logic [IDX_W-1:0] idx;
   logic [4:0]       run;
   logic             ones;
   logic             done_q;
   logic             cfg_take;
   logic             dat_take;
   logic             word_end;

   assign dat_nxt = dat_sh << 1;
   assign done    = done_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      cfg_ready  = 1'b0;
      dat_ready  = 1'b0;
      str        = 1'b0;
      mode       = 1'b0;
      busy       = 1'b0;
      cfg_take   = 1'b0;
      dat_take   = 1'b0;
      word_end   = 1'b0;
      case (state)
         IDLE: begin
            str       = 1'b1;
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               cfg_take   = 1'b1;
               next_state = LOAD;
            end
         end
         LOAD: begin
            mode = 1'b1;
            busy = 1'b1;
            str  = cfg_sh[TOT-1];
            if (cnt == CNT_LAST) next_state = START;
         end
         START: begin
            busy       = 1'b1;
            next_state = WAIT_DAT;
         end
         WAIT_DAT: begin
            cfg_ready = 1'b1;
            dat_ready = 1'b1;
            // payload wins over a concurrent re-key; the cfg offer stays pending
            if (dat_valid) begin
               dat_take   = 1'b1;
               next_state = SEND;
            end else if (cfg_valid) begin
               cfg_take   = 1'b1;
               next_state = LOAD;
            end
         end
         SEND: begin
            busy = 1'b1;
            str  = ones;
            if (run == 5'd0 && !ones && idx == '0) begin
               word_end   = 1'b1;
               next_state = WAIT_DAT;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_sh <= '0;
         cnt    <= '0;
         dat_sh <= '0;
         idx    <= '0;
         run    <= '0;
         ones   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= word_end;
         if (cfg_take) begin
            cfg_sh <= {cfg_n, cfg_d, cfg_mod};
            cnt    <= '0;
         end else if (state == LOAD) begin
            cfg_sh <= cfg_sh << 1;
            cnt    <= cnt + 1'b1;
         end
         // run holds remaining cycles minus one of the current phase
         if (dat_take) begin
            dat_sh <= dat_bits;
            idx    <= IDX_TOP;
            ones   <= 1'b1;
            run    <= dat_bits[KEY_W-1] ? HI_M1 : LO_M1;
         end else if (state == SEND) begin
            if (run != 5'd0) begin
               run <= run - 1'b1;
            end else if (ones) begin
               ones <= 1'b0;
               run  <= dat_sh[KEY_W-1] ? LO_M1 : HI_M1;
            end else if (idx != '0) begin
               idx    <= idx - 1'b1;
               dat_sh <= dat_nxt;
               ones   <= 1'b1;
               run    <= dat_nxt[KEY_W-1] ? HI_M1 : LO_M1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sam_sequencer.sv
// tb/tb_sam_sequencer.sv - randomized and directed bench for sam_sequencer with a waveform-queue model
module tb_sam_sequencer;

   localparam int KEY_W = 32;
   localparam int N_W   = 4;
   localparam int HI    = 12;
   localparam int LO    = 5;
   localparam int TOT   = N_W + 2 * KEY_W;

   // expected output tuple: {str, mode, busy, done, cfg_ready, dat_ready}
   localparam logic [5:0] IDLE_O = 6'b100010;
   localparam logic [5:0] WAIT_O = 6'b000011;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [N_W-1:0]   cfg_n = '0;
   logic [KEY_W-1:0] cfg_d = '0;
   logic [KEY_W-1:0] cfg_mod = '0;
   logic             dat_valid = 1'b0;
   logic             dat_ready;
   logic [KEY_W-1:0] dat_bits = '0;
   logic             str;
   logic             mode;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [5:0] q[$];
   logic       configured = 1'b0;

   sam_sequencer #(.KEY_W(KEY_W), .N_W(N_W), .HI_LEN(HI), .LO_LEN(LO)) dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_n(cfg_n), .cfg_d(cfg_d), .cfg_mod(cfg_mod),
      .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_bits(dat_bits),
      .str(str), .mode(mode), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] exp_now();
      if (q.size() != 0) return q[0];
      return configured ? WAIT_O : IDLE_O;
   endfunction

   task automatic push_cfg(input logic [N_W-1:0] n, input logic [KEY_W-1:0] d, input logic [KEY_W-1:0] m);
      logic [TOT-1:0] v;
      v = {n, d, m};
      for (int i = 0; i < TOT; i++) q.push_back({v[TOT-1-i], 5'b11000});
      q.push_back(6'b001000);
   endtask

   task automatic push_word(input logic [KEY_W-1:0] w);
      int ones_len;
      for (int b = KEY_W - 1; b >= 0; b--) begin
         ones_len = w[b] ? HI : LO;
         for (int i = 0; i < ones_len; i++) q.push_back(6'b101000);
         for (int i = 0; i < HI + LO - ones_len; i++) q.push_back(6'b001000);
      end
      q.push_back(6'b000111);
   endtask

   // model: advance one cycle per rising edge, starting new sequences on accepted transfers
   always @(posedge clk) begin
      logic [5:0] cur;
      if (!reset) begin
         q.delete();
         configured = 1'b0;
      end else begin
         cur = exp_now();
         if (q.size() != 0) void'(q.pop_front());
         if (cur[0] && dat_valid) begin
            push_word(dat_bits);
         end else if (cur[1] && cfg_valid) begin
            push_cfg(cfg_n, cfg_d, cfg_mod);
            configured = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      logic [5:0] e;
      e = reset ? exp_now() : IDLE_O;
      chk("cycle_outputs", {str, mode, busy, done, cfg_ready, dat_ready}, e);
   end

   task automatic wait_ready();
      int c;
      c = 0;
      while (!dat_ready && c < 2000) begin
         @(negedge clk);
         c++;
      end
      chk("wait_dat_ready", dat_ready, 1'b1);
   endtask

   // entered at a negedge where cfg_ready is high and dat_valid is low
   task automatic cfg_check(input logic [N_W-1:0] n, input logic [KEY_W-1:0] d, input logic [KEY_W-1:0] m);
      logic [TOT-1:0] lv;
      int bad, mcnt;
      lv = {n, d, m};
      bad = 0;
      mcnt = 0;
      cfg_n = n; cfg_d = d; cfg_mod = m; cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      for (int i = 0; i < TOT; i++) begin
         if (mode === 1'b1) mcnt++;
         if (str !== lv[TOT-1-i]) bad++;
         @(negedge clk);
      end
      chk("load_mode_cycles", mcnt, TOT);
      chk("load_bit_errors", bad, 0);
      chk("start_marker", {str, mode, busy}, 3'b001);
      @(negedge clk);
      chk("ready_after_load", {cfg_ready, dat_ready, mode, str}, 4'b1100);
   endtask

   initial begin
      logic s[KEY_W * (HI + LO)];
      int bcnt, ocnt;
      logic [KEY_W-1:0] w;

      #1 chk("reset_outputs_async", {str, mode, busy, done, cfg_ready, dat_ready}, IDLE_O);
      repeat (3) @(negedge clk);
      chk("reset_outputs", {str, mode, busy, done, cfg_ready, dat_ready}, IDLE_O);
      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_release", {str, mode, cfg_ready, dat_ready}, 4'b1010);

      cfg_check(4'h5, 32'hA5A5_0F0F, 32'h1234_5678);

      // single word 0x8000_0001
      dat_bits = 32'h8000_0001; dat_valid = 1'b1;
      @(negedge clk);
      dat_valid = 1'b0;
      bcnt = 0; ocnt = 0;
      for (int i = 0; i < KEY_W * (HI + LO); i++) begin
         s[i] = str;
         if (busy === 1'b1) bcnt++;
         if (str === 1'b1) ocnt++;
         chk("no_early_done", done, 1'b0);
         @(negedge clk);
      end
      chk("word_busy_cycles", bcnt, 544);
      chk("word_ones_total", ocnt, 174);
      chk("msb_run_edges", {s[0], s[11], s[12], s[16], s[17], s[21], s[22]}, 7'b1100110);
      chk("lsb_run_edges", {s[526], s[527], s[538], s[539], s[543]}, 5'b01100);
      chk("done_pulse", {done, dat_ready, busy}, 3'b110);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);

      // back-to-back with dat_valid held
      dat_bits = 32'hC3C3_0001; dat_valid = 1'b1;
      @(negedge clk);
      repeat (544) @(negedge clk);
      chk("b2b_done", done, 1'b1);
      @(negedge clk);
      chk("b2b_second_starts", {busy, str, done}, 3'b110);
      dat_valid = 1'b0;
      wait_ready();

      // simultaneous cfg+dat: data wins, cfg stays pending through SEND then re-keys
      cfg_n = 4'hA; cfg_d = $urandom; cfg_mod = $urandom; cfg_valid = 1'b1;
      dat_bits = $urandom; dat_valid = 1'b1;
      @(negedge clk);
      dat_valid = 1'b0;
      chk("simul_send_entered", {busy, cfg_ready, dat_ready, mode}, 4'b1000);
      repeat (544) @(negedge clk);
      chk("simul_done", {done, cfg_ready}, 2'b11);
      @(negedge clk);
      chk("rekey_load_starts", {mode, str}, 2'b11);
      cfg_valid = 1'b0;
      wait_ready();

      // reset in the middle of a word
      dat_bits = 32'hFFFF_0000; dat_valid = 1'b1;
      @(negedge clk);
      dat_valid = 1'b0;
      repeat (17 * 17 + 3) @(negedge clk);
      #2 reset = 1'b0;
      #1 chk("mid_send_reset", {str, mode, busy, done, cfg_ready, dat_ready}, IDLE_O);
      @(negedge clk);
      #2 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_done_after_reset", {done, str}, 2'b01);
      end
      cfg_check(4'h9, 32'h0F0F_F0F0, 32'hDEAD_BEEF);

      // randomized traffic
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 2999) == 0) begin
            #2 reset = 1'b0;
            @(negedge clk);
            #2 reset = 1'b1;
         end
         cfg_valid = ($urandom_range(0, 99) < 3);
         cfg_n     = N_W'($urandom);
         cfg_d     = $urandom;
         cfg_mod   = $urandom;
         dat_valid = ($urandom_range(0, 3) == 0);
         w         = $urandom;
         dat_bits  = w;
      end
      cfg_valid = 1'b0;
      dat_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
      $fatal(1);
   end

endmodule
